// File: rtl/obi_seq_mgr.sv
// OBI manager that writes an incrementing pattern to a word-aligned region, or reads it back.
// Define OBI_SEQ_MGR_RDCHECK_EN to compare read data against the pattern and count mismatches.

package obi_seq_mgr_pkg;

   typedef struct packed {
      int unsigned AddrWidth;
      int unsigned DataWidth;
      int unsigned IdWidth;
   } obi_cfg_t;

   localparam obi_cfg_t MgrObiCfg = '{AddrWidth: 32, DataWidth: 32, IdWidth: 1};

   typedef struct packed {
      logic [31:0] addr;
      logic        we;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic [0:0]  aid;
      logic        a_optional;
   } mgr_obi_a_chan_t;

   typedef struct packed {
      mgr_obi_a_chan_t a;
      logic            req;
   } mgr_obi_req_t;

   typedef struct packed {
      logic [31:0] rdata;
      logic [0:0]  rid;
      logic        err;
      logic        r_optional;
   } mgr_obi_r_chan_t;

   typedef struct packed {
      mgr_obi_r_chan_t r;
      logic            gnt;
      logic            rvalid;
   } mgr_obi_rsp_t;

endpackage

module obi_seq_mgr #(
   parameter obi_seq_mgr_pkg::obi_cfg_t ObiCfg = obi_seq_mgr_pkg::MgrObiCfg,
   parameter type obi_req_t = obi_seq_mgr_pkg::mgr_obi_req_t,
   parameter type obi_rsp_t = obi_seq_mgr_pkg::mgr_obi_rsp_t,
   parameter int unsigned LenWidth = 16
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic                          start_i,
   input  logic                          we_i,
   input  logic [ObiCfg.AddrWidth-1:0]   base_addr_i,
   input  logic [LenWidth-1:0]           len_i,
   input  logic [ObiCfg.DataWidth-1:0]   seed_i,
   output logic                          busy_o,
   output logic                          done_o,
   output logic                          err_o,
   output logic [LenWidth-1:0]           err_cnt_o,
   output logic [LenWidth-1:0]           mismatch_cnt_o,
   output obi_req_t                      obi_req_o,
   input  obi_rsp_t                      obi_rsp_i
);

   localparam int unsigned AddrWidth = ObiCfg.AddrWidth;
   localparam int unsigned DataWidth = ObiCfg.DataWidth;

   typedef enum logic [1:0] {Idle, Req, Rsp, Done} state_e;

   state_e                 state_q, state_d;
   logic                   we_q;
   logic [AddrWidth-1:0]   addr_q;
   logic [DataWidth-1:0]   data_q;
   logic [LenWidth-1:0]    len_q;
   logic [LenWidth-1:0]    k_q;
   logic                   err_q;
   logic [LenWidth-1:0]    err_cnt_q;
   logic                   start_ok;
   logic                   rsp_evt;
   logic                   last_word;
   logic                   unused_rsp;

   assign start_ok  = (state_q == Idle) && start_i;
   assign rsp_evt   = (state_q == Rsp) && obi_rsp_i.rvalid;
   assign last_word = (k_q == (len_q - LenWidth'(1)));

   assign unused_rsp = ^{obi_rsp_i.r.rid, obi_rsp_i.r.r_optional, obi_rsp_i.r.rdata};

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= Idle;
      end else begin
         state_q <= state_d;
      end
   end

   // The request channel is driven only in Req so it is all-zero everywhere else, including reset.
   always_comb begin
      state_d   = state_q;
      obi_req_o = '0;
      busy_o    = 1'b0;
      done_o    = 1'b0;
      case (state_q)
         Idle: begin
            if (start_i) begin
               state_d = (len_i == '0) ? Done : Req;
            end
         end
         Req: begin
            busy_o            = 1'b1;
            obi_req_o.req     = 1'b1;
            obi_req_o.a.addr  = addr_q;
            obi_req_o.a.we    = we_q;
            obi_req_o.a.be    = 4'hF;
            obi_req_o.a.wdata = we_q ? data_q : '0;
            if (obi_rsp_i.gnt) begin
               state_d = Rsp;
            end
         end
         Rsp: begin
            busy_o = 1'b1;
            if (obi_rsp_i.rvalid) begin
               state_d = last_word ? Done : Req;
            end
         end
         Done: begin
            done_o  = 1'b1;
            state_d = Idle;
         end
         default: state_d = Idle;
      endcase
   end

   // Address and pattern advance together on each response; counters persist until the next start.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         we_q      <= 1'b0;
         addr_q    <= '0;
         data_q    <= '0;
         len_q     <= '0;
         k_q       <= '0;
         err_q     <= 1'b0;
         err_cnt_q <= '0;
      end else if (start_ok) begin
         we_q      <= we_i;
         addr_q    <= {base_addr_i[AddrWidth-1:2], 2'b00};
         data_q    <= seed_i;
         len_q     <= len_i;
         k_q       <= '0;
         err_q     <= 1'b0;
         err_cnt_q <= '0;
      end else if (rsp_evt) begin
         if (obi_rsp_i.r.err) begin
            err_q <= 1'b1;
            if (err_cnt_q != '1) begin
               err_cnt_q <= err_cnt_q + LenWidth'(1);
            end
         end
         k_q    <= k_q + LenWidth'(1);
         addr_q <= addr_q + AddrWidth'(4);
         data_q <= data_q + DataWidth'(1);
      end
   end

   assign err_o     = err_q;
   assign err_cnt_o = err_cnt_q;

`ifdef OBI_SEQ_MGR_RDCHECK_EN
   logic [LenWidth-1:0] mis_cnt_q;

   // Error responses carry no meaningful data, so only clean read responses are compared.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         mis_cnt_q <= '0;
      end else if (start_ok) begin
         mis_cnt_q <= '0;
      end else if (rsp_evt && !we_q && !obi_rsp_i.r.err &&
                   (obi_rsp_i.r.rdata != data_q) && (mis_cnt_q != '1)) begin
         mis_cnt_q <= mis_cnt_q + LenWidth'(1);
      end
   end

   assign mismatch_cnt_o = mis_cnt_q;
`else
   assign mismatch_cnt_o = '0;
`endif

endmodule

// File: tb/tb_obi_seq_mgr.sv
// Directed bench for obi_seq_mgr with a simple OBI subordinate model (grant stall, error, read table).

module tb_obi_seq_mgr;

   logic        clk;
   logic        rst;
   logic        start;
   logic        we_in;
   logic [31:0] base;
   logic [15:0] len;
   logic [31:0] seed;
   logic        busy;
   logic        done;
   logic        err;
   logic [15:0] err_cnt;
   logic [15:0] mis_cnt;

   obi_seq_mgr_pkg::mgr_obi_req_t obi_req;
   obi_seq_mgr_pkg::mgr_obi_rsp_t obi_rsp;

   int total = 0;
   int bad   = 0;

   // Subordinate model controls and state
   logic        slv_err;
   int          stall_req;
   logic [31:0] rdata_tab [4];
   logic        gnt;
   logic        rvalid_q;
   logic [31:0] rdata_q;
   logic        rerr_q;
   int          stall_cnt;
   int          log_n = 0;
   logic [31:0] log_addr  [64];
   logic [31:0] log_wdata [64];
   logic        log_we    [64];

   obi_seq_mgr #(
      .LenWidth(16)
   ) dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .start_i        (start),
      .we_i           (we_in),
      .base_addr_i    (base),
      .len_i          (len),
      .seed_i         (seed),
      .busy_o         (busy),
      .done_o         (done),
      .err_o          (err),
      .err_cnt_o      (err_cnt),
      .mismatch_cnt_o (mis_cnt),
      .obi_req_o      (obi_req),
      .obi_rsp_i      (obi_rsp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign gnt = obi_req.req && (stall_cnt >= stall_req);

   always_comb begin
      obi_rsp         = '0;
      obi_rsp.gnt     = gnt;
      obi_rsp.rvalid  = rvalid_q;
      obi_rsp.r.rdata = rdata_q;
      obi_rsp.r.err   = rerr_q;
   end

   // Responds one cycle after each grant and logs every granted request.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         rvalid_q  <= 1'b0;
         rdata_q   <= '0;
         rerr_q    <= 1'b0;
         stall_cnt <= 0;
      end else begin
         rvalid_q <= obi_req.req && gnt;
         rdata_q  <= slv_err ? 32'hBADC_AB1E : rdata_tab[obi_req.a.addr[3:2]];
         rerr_q   <= slv_err;
         if (obi_req.req && !gnt) stall_cnt <= stall_cnt + 1;
         else                     stall_cnt <= 0;
         if (obi_req.req && gnt) begin
            log_addr[log_n]  <= obi_req.a.addr;
            log_wdata[log_n] <= obi_req.a.wdata;
            log_we[log_n]    <= obi_req.a.we;
            log_n            <= log_n + 1;
         end
      end
   end

   task automatic check_output(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
      total++;
      assert (observed === expected)
      else begin
         bad++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Pulses start for one cycle and waits (bounded) for done; done_n is -1 on timeout.
   task automatic apply_stimulus(input logic w, input logic [31:0] b, input logic [15:0] l,
                                 input logic [31:0] s, output int done_n,
                                 output logic req1, output logic busy1);
      @(negedge clk);
      start = 1'b1; we_in = w; base = b; len = l; seed = s;
      @(posedge clk);
      done_n = -1; req1 = 1'b0; busy1 = 1'b0;
      for (int n = 1; n <= 200; n++) begin
         @(negedge clk);
         start = 1'b0;
         if (n == 1) begin
            req1  = obi_req.req;
            busy1 = busy;
         end
         if (done) begin
            done_n = n;
            break;
         end
      end
   endtask

   initial begin
      int   dn;
      int   b0;
      logic r1;
      logic bz1;
      logic [31:0] exp_mis;

      rst = 1'b1; start = 1'b0; we_in = 1'b0; base = '0; len = '0; seed = '0;
      slv_err = 1'b0; stall_req = 0;
      rdata_tab[0] = 32'h0; rdata_tab[1] = 32'h0; rdata_tab[2] = 32'h0; rdata_tab[3] = 32'h0;

      repeat (3) @(negedge clk);
      check_output("rst_req_zero", (obi_req === '0) ? 32'd0 : 32'd1, 32'd0);
      check_output("rst_busy", 32'(busy), 32'd0);
      check_output("rst_done", 32'(done), 32'd0);
      check_output("rst_err", 32'(err), 32'd0);
      check_output("rst_err_cnt", 32'(err_cnt), 32'd0);
      check_output("rst_mis_cnt", 32'(mis_cnt), 32'd0);
      rst = 1'b0;

      // Write sequence, len 4
      b0 = log_n;
      apply_stimulus(1'b1, 32'h2000_0000, 16'd4, 32'hA5A5_0000, dn, r1, bz1);
      check_output("wr_done_cycle", 32'(dn), 32'd9);
      check_output("wr_req_latency", 32'(r1), 32'd1);
      check_output("wr_busy_c1", 32'(bz1), 32'd1);
      check_output("wr_busy_at_done", 32'(busy), 32'd0);
      check_output("wr_err_cnt", 32'(err_cnt), 32'd0);
      check_output("wr_count", 32'(log_n - b0), 32'd4);
      for (int i = 0; i < 4; i++) begin
         check_output("wr_addr", log_addr[b0+i], 32'h2000_0000 + 32'(4*i));
         check_output("wr_wdata", log_wdata[b0+i], 32'hA5A5_0000 + 32'(i));
         check_output("wr_we", 32'(log_we[b0+i]), 32'd1);
      end

      // Read from error-terminating subordinate
      slv_err = 1'b1;
      b0 = log_n;
      apply_stimulus(1'b0, 32'h3000_0002, 16'd3, 32'h0, dn, r1, bz1);
      check_output("err_done_cycle", 32'(dn), 32'd7);
      check_output("err_flag", 32'(err), 32'd1);
      check_output("err_cnt", 32'(err_cnt), 32'd3);
      check_output("err_mis_cnt", 32'(mis_cnt), 32'd0);
      check_output("err_first_addr", log_addr[b0], 32'h3000_0000);
      check_output("err_rd_wdata", log_wdata[b0], 32'h0);
      slv_err = 1'b0;

      // Read with one mismatching word
      rdata_tab[0] = 32'h10; rdata_tab[1] = 32'h99;
      apply_stimulus(1'b0, 32'h0, 16'd2, 32'h10, dn, r1, bz1);
`ifdef OBI_SEQ_MGR_RDCHECK_EN
      exp_mis = 32'd1;
`else
      exp_mis = 32'd0;
`endif
      check_output("mis_done_cycle", 32'(dn), 32'd5);
      check_output("mis_cnt", 32'(mis_cnt), exp_mis);
      check_output("mis_err_cleared", 32'(err), 32'd0);
      check_output("mis_err_cnt_cleared", 32'(err_cnt), 32'd0);

      // Grant stalled 5 cycles, start pulses ignored meanwhile
      stall_req = 5;
      b0 = log_n;
      @(negedge clk);
      start = 1'b1; we_in = 1'b1; base = 32'h40; len = 16'd1; seed = 32'h7;
      @(posedge clk);
      dn = -1;
      for (int n = 1; n <= 200; n++) begin
         @(negedge clk);
         start = (n == 2 || n == 3);
         if (n == 2) begin
            we_in = 1'b0; base = 32'h999; len = 16'd5; seed = 32'h55;
         end
         if (n <= 5) begin
            check_output("stall_req", 32'(obi_req.req), 32'd1);
            check_output("stall_addr", obi_req.a.addr, 32'h40);
            check_output("stall_wdata", obi_req.a.wdata, 32'h7);
            check_output("stall_we", 32'(obi_req.a.we), 32'd1);
         end
         if (done) begin
            dn = n;
            break;
         end
      end
      start = 1'b0;
      stall_req = 0;
      check_output("stall_done_cycle", 32'(dn), 32'd8);
      check_output("stall_count", 32'(log_n - b0), 32'd1);
      check_output("stall_log_addr", log_addr[b0], 32'h40);
      repeat (3) @(negedge clk);
      check_output("stall_idle_after", 32'(obi_req.req), 32'd0);

      // Address and pattern wrap
      b0 = log_n;
      apply_stimulus(1'b1, 32'hFFFF_FFF8, 16'd3, 32'hFFFF_FFFF, dn, r1, bz1);
      check_output("wrap_done_cycle", 32'(dn), 32'd7);
      check_output("wrap_addr0", log_addr[b0],   32'hFFFF_FFF8);
      check_output("wrap_addr1", log_addr[b0+1], 32'hFFFF_FFFC);
      check_output("wrap_addr2", log_addr[b0+2], 32'h0000_0000);
      check_output("wrap_wdata0", log_wdata[b0],   32'hFFFF_FFFF);
      check_output("wrap_wdata1", log_wdata[b0+1], 32'h0000_0000);
      check_output("wrap_wdata2", log_wdata[b0+2], 32'h0000_0001);

      // Zero length
      b0 = log_n;
      apply_stimulus(1'b1, 32'h1000, 16'd0, 32'h1, dn, r1, bz1);
      check_output("len0_done_cycle", 32'(dn), 32'd1);
      check_output("len0_no_req", 32'(r1), 32'd0);
      check_output("len0_busy", 32'(bz1), 32'd0);
      @(negedge clk);
      check_output("len0_done_pulse", 32'(done), 32'd0);
      check_output("len0_no_traffic", 32'(log_n - b0), 32'd0);

      // Reset while waiting for a response
      slv_err = 1'b1;
      @(negedge clk);
      start = 1'b1; we_in = 1'b0; base = 32'h500; len = 16'd3; seed = 32'h0;
      @(posedge clk);
      @(negedge clk); start = 1'b0;
      repeat (3) @(negedge clk);
      check_output("mid_busy", 32'(busy), 32'd1);
      check_output("mid_err_cnt", 32'(err_cnt), 32'd1);
      rst = 1'b1;
      #1;
      check_output("abort_req_zero", (obi_req === '0) ? 32'd0 : 32'd1, 32'd0);
      check_output("abort_busy", 32'(busy), 32'd0);
      check_output("abort_done", 32'(done), 32'd0);
      check_output("abort_err", 32'(err), 32'd0);
      check_output("abort_err_cnt", 32'(err_cnt), 32'd0);
      check_output("abort_mis_cnt", 32'(mis_cnt), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      slv_err = 1'b0;
      repeat (3) @(negedge clk);
      check_output("post_rst_req", 32'(obi_req.req), 32'd0);
      check_output("post_rst_busy", 32'(busy), 32'd0);
      check_output("post_rst_err_cnt", 32'(err_cnt), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
